scope_capture_ctrl: RTL

- Trigger and acquisition controller for the oscilloscope datapath.
- Watches the ADC sample stream, detects a trigger edge and writes one 256-sample record into the back bank of a double-buffered capture RAM.
- Swaps banks only during VGA vertical blanking, so the display drawing stage always reads a complete, stable record.
- Sits between the ADC sample stream and the display sample memory.

---
 rtl/scope_capture_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: trigger detection and double-buffered 256-sample record capture for the scope datapath.
// Optional hysteresis qualification of the trigger edge is compiled in with `define SCOPE_TRIG_HYST_EN.
module scope_capture_ctrl #(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 12,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int HYST         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    input  logic              vblnk,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              buf_sel,
    output logic              frame_ready,
    output logic              triggered,
    output logic              busy
);
    localparam int         TO_W        = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, SWAP} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              trig_flag;
    logic              vblnk_d;
    logic [1:0]        mode_q;
    logic              edge_raw;
    logic              edge_hit;
    logic              trig_hit;
    logic              timeout_hit;
    logic              start_cap;
    logic              cap_write;
    logic              cap_last;
    logic              swap_now;

    always_comb begin
        if (trig_slope)
            edge_raw = prev_valid && (prev > trig_level) && (sample_data <= trig_level);
        else
            edge_raw = prev_valid && (prev < trig_level) && (sample_data >= trig_level);
    end

`ifdef SCOPE_TRIG_HYST_EN
    logic              hyst_ok;
    logic              far_side;
    logic [DATA_W:0]   band_hi_ext;
    logic [DATA_W-1:0] band_lo;
    logic [DATA_W-1:0] band_hi;

    // Band edges saturate so a level near either rail never wraps around.
    always_comb begin
        band_lo     = (trig_level >= DATA_W'(HYST)) ? trig_level - DATA_W'(HYST) : '0;
        band_hi_ext = {1'b0, trig_level} + (DATA_W+1)'(HYST);
        band_hi     = band_hi_ext[DATA_W] ? '1 : band_hi_ext[DATA_W-1:0];
        far_side    = trig_slope ? (sample_data > band_hi) : (sample_data < band_lo);
    end

    // Qualifier is cleared outside WAIT_TRIG, so every entry into WAIT_TRIG re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hyst_ok <= 1'b0;
        else if (state != WAIT_TRIG)
            hyst_ok <= 1'b0;
        else if (sample_valid && far_side)
            hyst_ok <= 1'b1;
    end

    assign edge_hit = edge_raw && hyst_ok;
`else
    assign edge_hit = edge_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (trig_mode != MODE_SINGLE || arm) state_nxt = WAIT_TRIG;
            WAIT_TRIG: if (start_cap) state_nxt = CAPTURE;
            CAPTURE:   if (cap_last) state_nxt = SWAP;
            SWAP:      if (swap_now) state_nxt = (mode_q == MODE_SINGLE) ? IDLE : WAIT_TRIG;
            default:   state_nxt = IDLE;
        endcase
    end

    // A real edge takes priority over the auto-mode timeout on the same sample.
    always_comb begin
        busy        = (state != IDLE);
        trig_hit    = 1'b0;
        timeout_hit = 1'b0;
        cap_write   = 1'b0;
        cap_last    = 1'b0;
        swap_now    = 1'b0;
        case (state)
            WAIT_TRIG: begin
                trig_hit    = sample_valid && edge_hit;
                timeout_hit = sample_valid && !edge_hit && (mode_q == MODE_AUTO) &&
                              (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
            end
            CAPTURE: begin
                cap_write = sample_valid;
                cap_last  = sample_valid && (addr_cnt == ADDR_W'(DEPTH - 1));
            end
            SWAP:    swap_now = vblnk && !vblnk_d;
            default: ;
        endcase
        start_cap = trig_hit || timeout_hit;
    end

    // wr_bank tracks the bank that will be the back bank after this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev        <= '0;
            prev_valid  <= 1'b0;
            to_cnt      <= '0;
            addr_cnt    <= '0;
            trig_flag   <= 1'b0;
            vblnk_d     <= 1'b0;
            mode_q      <= 2'b00;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            buf_sel     <= 1'b0;
            frame_ready <= 1'b0;
            triggered   <= 1'b0;
        end else begin
            vblnk_d     <= vblnk;
            frame_ready <= swap_now;
            wr_en       <= start_cap || cap_write;
            wr_bank     <= swap_now ? buf_sel : ~buf_sel;
            if (start_cap || cap_write) begin
                wr_addr <= start_cap ? '0 : addr_cnt;
                wr_data <= sample_data;
            end
            case (state)
                IDLE: begin
                    mode_q     <= trig_mode;
                    prev_valid <= 1'b0;
                    to_cnt     <= '0;
                    addr_cnt   <= '0;
                end
                WAIT_TRIG: begin
                    if (sample_valid) begin
                        prev       <= sample_data;
                        prev_valid <= 1'b1;
                        if (start_cap) begin
                            trig_flag <= trig_hit;
                            addr_cnt  <= ADDR_W'(1);
                        end else if (mode_q == MODE_AUTO) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (cap_write)
                        addr_cnt <= addr_cnt + 1'b1;
                end
                SWAP: begin
                    if (swap_now) begin
                        buf_sel    <= ~buf_sel;
                        triggered  <= trig_flag;
                        mode_q     <= trig_mode;
                        prev_valid <= 1'b0;
                        to_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
